// File: rtl/pong_pkg.sv
// pong_pkg: shared screen, VGA 640x480@60 timing, reset-default and colour constants for the Pong renderer.
package pong_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int H_VISIBLE = SCREEN_W;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = SCREEN_H;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] BALL_X_RST = 10'd320;
  localparam logic [9:0] BALL_Y_RST = 10'd240;
  localparam logic [9:0] PADDLE_Y_RST = 10'd210;
  localparam logic [5:0] NET_COLOR = 6'b010101;
  localparam int NET_X_LO = 318;
  localparam int NET_X_HI = 321;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with raw active-low syncs, visible flag and frame_start strobe at (0,480).
module vga_timing
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_start
);
  always_ff @(posedge clk)
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == 10'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
    end else
      hcnt <= hcnt + 1'b1;
  assign hsync = !(hcnt >= 10'(H_VISIBLE + H_FRONT) && hcnt < 10'(H_VISIBLE + H_FRONT + H_SYNC));
  assign vsync = !(vcnt >= 10'(V_VISIBLE + V_FRONT) && vcnt < 10'(V_VISIBLE + V_FRONT + V_SYNC));
  assign visible = hcnt < 10'(H_VISIBLE) && vcnt < 10'(V_VISIBLE);
  assign frame_start = hcnt == '0 && vcnt == 10'(V_VISIBLE);
endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: draws ball, paddle and (with PONG_RENDER_NET_EN) a dashed centre net onto a 640x480 VGA stream.
// Positions are shadow-latched at the start of vertical blanking so each frame shows one consistent snapshot.
module pong_vga_renderer
  import pong_pkg::*;
#(
  parameter int         BALL_SIZE = 10,
  parameter int         PADDLE_WIDTH = 10,
  parameter int         PADDLE_HEIGHT = 60,
  parameter logic [5:0] FG_COLOR = 6'b111111,
  parameter logic [5:0] BG_COLOR = 6'b000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [5:0] rgb,
  output logic       frame_tick
);
  logic [9:0] hcnt, vcnt, bx, by, py;
  logic [10:0] h, v;
  logic hs, vs, vis, fs, ball_hit, paddle_hit;
  logic [5:0] color;
  vga_timing u_timing (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt),
    .hsync(hs), .vsync(vs), .visible(vis), .frame_start(fs)
  );
  // 11-bit compares keep a ball near the right/bottom edge clipped instead of wrapping
  assign h = {1'b0, hcnt};
  assign v = {1'b0, vcnt};
  assign ball_hit = h >= {1'b0, bx} && h < {1'b0, bx} + 11'(BALL_SIZE) &&
                    v >= {1'b0, by} && v < {1'b0, by} + 11'(BALL_SIZE);
  assign paddle_hit = h < 11'(PADDLE_WIDTH) && v >= {1'b0, py} && v < {1'b0, py} + 11'(PADDLE_HEIGHT);
`ifdef PONG_RENDER_NET_EN
  logic net_hit;
  assign net_hit = hcnt >= 10'(NET_X_LO) && hcnt <= 10'(NET_X_HI) && !vcnt[4];
  assign color = (ball_hit || paddle_hit) ? FG_COLOR : net_hit ? NET_COLOR : BG_COLOR;
`else
  assign color = (ball_hit || paddle_hit) ? FG_COLOR : BG_COLOR;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      bx <= BALL_X_RST;
      by <= BALL_Y_RST;
      py <= PADDLE_Y_RST;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de <= 1'b0;
      rgb <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (fs) begin
        bx <= ball_x;
        by <= ball_y;
        py <= paddle_y;
      end
      hsync <= hs;
      vsync <= vs;
      de <= vis;
      rgb <= vis ? color : '0;
      frame_tick <= fs;
    end
endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer: random position stimulus checked every cycle against a pixel-rule model, plus literal frame checks.
module tb_pong_vga_renderer;
  localparam logic [5:0] FG = 6'b111111;
  localparam logic [9:0] RST_OUT = 10'b11_0_000000_0;
  logic clk = 0, rst = 1;
  logic [9:0] ball_x = 0, ball_y = 0, paddle_y = 0;
  logic hsync, vsync, de, frame_tick;
  logic [5:0] rgb;
  int n_cmp = 0, n_bad = 0;
  int mh = 0, mv = 0, ph = 0, pv = 0, sbx = 320, sby = 240, spy = 210;
  int cyc = 0, t0 = 0, hf = 0, vf = 0, n_tick = 0;
  int fgcnt = 0;
  int minx[480];
  int rowcnt[480];
  bit e_valid = 0, started = 0, rand_en = 0, hs_q = 1, vs_q = 1;
  logic [9:0] e_out = RST_OUT;

  pong_vga_renderer dut (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [5:0] pix(input int x, input int y);
    if (x >= sbx && x < sbx + 10 && y >= sby && y < sby + 10) return FG;
    if (x < 10 && y >= spy && y < spy + 60) return FG;
`ifdef PONG_RENDER_NET_EN
    if (x >= 318 && x <= 321 && (y % 32) < 16) return 6'b010101;
`endif
    return 6'b000000;
  endfunction

  // reference model: outputs describe the pixel at the counter state of the previous cycle
  always @(posedge clk) begin
    started = 1;
    cyc++;
    if (rst) begin
      e_valid = 0;
      e_out = RST_OUT;
      mh = 0; mv = 0;
      sbx = 320; sby = 240; spy = 210;
    end else begin
      bit vis;
      vis = mh < 640 && mv < 480;
      ph = mh; pv = mv; e_valid = 1;
      e_out = {!(mh >= 656 && mh < 752), !(mv >= 490 && mv < 492), vis, vis ? pix(mh, mv) : 6'b0,
               mh == 0 && mv == 480};
      if (mh == 0 && mv == 480) begin
        sbx = ball_x; sby = ball_y; spy = paddle_y;
      end
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else mh++;
    end
  end

  always @(negedge clk) if (started) begin
    chk("pixel", {hsync, vsync, de, rgb, frame_tick}, e_out);
    if (e_valid && ph == 0 && pv == 0) begin
      fgcnt = 0;
      for (int i = 0; i < 480; i++) begin minx[i] = 9999; rowcnt[i] = 0; end
    end
    if (e_valid && ph < 640 && pv < 480 && rgb == FG) begin
      fgcnt++;
      rowcnt[pv]++;
      if (ph >= 10 && ph < minx[pv]) minx[pv] = ph;
    end
    if (t0 > 0) begin
      if (!hsync && hs_q) begin
        if (hf > t0) chk("hsync_period", cyc - hf, 800);
        hf = cyc;
      end
      if (hsync && !hs_q && hf > t0) chk("hsync_low", cyc - hf, 96);
      if (!vsync && vs_q) begin
        if (vf > t0) chk("vsync_period", cyc - vf, 420000);
        vf = cyc;
      end
      if (vsync && !vs_q && vf > t0) chk("vsync_low", cyc - vf, 1600);
      if (frame_tick && cyc > t0) n_tick++;
    end
    hs_q = hsync; vs_q = vsync;
    if (n_bad >= 50) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_en) begin
        ball_x = 10'($urandom_range(0, 1023));
        ball_y = 10'($urandom_range(0, 1023));
        paddle_y = 10'($urandom_range(0, 1023));
      end
    end
  endtask

  task automatic wait_pos(input int x, input int y);
    int b = 0;
    while (!(mh == x && mv == y) && b < 500000) begin step(1); b++; end
    if (b >= 500000) begin n_cmp++; n_bad++; $display("FAIL wait_pos(%0d,%0d): timed out", x, y); end
  endtask

  task automatic wait_tick(output int at);
    int b = 0;
    do begin step(1); b++; end while (frame_tick !== 1'b1 && b < 500000);
    at = cyc;
    if (b >= 500000) begin n_cmp++; n_bad++; $display("FAIL wait_tick: timed out"); end
  endtask

  initial begin
    int tk;
    step(3);
    chk("reset_outputs", {hsync, vsync, de, rgb, frame_tick}, RST_OUT);
    rst = 0;
    rand_en = 1;
    wait_pos(700, 300);
    rst = 1;
    step(1);
    chk("midframe_reset_outputs", {hsync, vsync, de, rgb, frame_tick}, RST_OUT);
    rst = 0;
    t0 = cyc;
    wait_pos(0, 470);
    rand_en = 0;
    ball_x = 100; ball_y = 50; paddle_y = 470;
    wait_tick(tk);
    chk("first_tick_latency", tk - t0, 384001);
    chk("default_frame_fg_pixels", fgcnt, 700);
    chk("default_ball_left_x", minx[245], 320);
    chk("default_paddle_row", rowcnt[215], 10);
    rand_en = 1;
    wait_pos(0, 200);
    rand_en = 0;
    ball_x = 300; ball_y = 50; paddle_y = 470;
    wait_tick(tk);
    chk("frame_period", tk - t0, 384001 + 420000);
    chk("frame_a_fg_pixels", fgcnt, 200);
    chk("frame_a_ball_left_x", minx[55], 100);
    chk("frame_a_ball_row_width", rowcnt[55], 10);
    chk("paddle_clipped_bottom", rowcnt[479], 10);
    chk("paddle_no_wrap_top", rowcnt[5], 0);
    wait_pos(0, 62);
    chk("frame_b_ball_left_x", minx[55], 300);
    chk("frame_b_no_old_ball", rowcnt[49], 0);
    chk("tick_count", n_tick, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pong_vga_renderer.md
# pong_vga_renderer

Downstream display stage of the Pong game: converts the game core's ball and paddle positions into a 640×480@60 Hz VGA pixel stream. It generates the sync timing and draws the ball, paddle and an optional centre net. It also returns a once-per-frame tick to the game core. Positions are shadow-latched once per frame so that a single frame never shows a mix of old and new positions.

## Interface
Parameters:
- `BALL_SIZE`, 10: ball edge length in pixels.
- `PADDLE_WIDTH`, 10: paddle width in pixels; the paddle occupies x = 0..PADDLE_WIDTH-1.
- `PADDLE_HEIGHT`, 60: paddle height in pixels.
- `FG_COLOR`, 6'b111111: ball and paddle colour, {R1,R0,G1,G0,B1,B0}.
- `BG_COLOR`, 6'b000000: background colour.

Ports:
- `clk`  input  1  pixel clock, 25.175 MHz nominal.
- `rst`  input  1  reset; synchronous, active-high.
- `ball_x`  input  10  ball left edge, pixels.
- `ball_y`  input  10  ball top edge, pixels.
- `paddle_y`  input  10  paddle top edge, pixels.
- `hsync`  output  1  horizontal sync, active-low.
- `vsync`  output  1  vertical sync, active-low.
- `de`  output  1  display enable; high during the visible region.
- `rgb`  output  6  pixel colour; forced to 0 when `de` is low.
- `frame_tick`  output  1  one-cycle pulse at the start of vertical blanking.

## Operation
- `hcnt` counts 0..799 and wraps to 0. `vcnt` advances when `hcnt` wraps, counts 0..524 and wraps to 0.
- Visible region: `hcnt` < 640 and `vcnt` < 480.
- Horizontal sync is active for `hcnt` 656..751. Vertical sync is active for `vcnt` 490..491.
- Shadow latch: at `hcnt`=0, `vcnt`=480, sample `ball_x`, `ball_y` and `paddle_y` into the shadow registers. `frame_tick` pulses in the same cycle.
- Ball hit: `bx` ≤ `hcnt` < `bx`+BALL_SIZE and `by` ≤ `vcnt` < `by`+BALL_SIZE, where `bx`/`by` are the shadowed ball positions. Compare in 11 bits so the sum never wraps. A ball partly off-screen is clipped, not wrapped.
- Paddle hit: `hcnt` < PADDLE_WIDTH and `py` ≤ `vcnt` < `py`+PADDLE_HEIGHT, in 11 bits, where `py` is the shadowed paddle position.
- Colour priority: ball, then paddle, then net (when compiled in), then `BG_COLOR`. Ball and paddle both use `FG_COLOR`.
- Reset values:
  - counters 0;
  - shadow registers `bx`=320, `by`=240, `py`=210;
  - `hsync`=1, `vsync`=1, `de`=0, `rgb`=0, `frame_tick`=0.
- Reset asserted mid-frame: the next cycle shows the reset values, and the frame restarts at (0,0).

## Timing
- All outputs are registered.
- The pixel evaluated at counter state (h,v) appears on the outputs 1 cycle later. `hsync`, `vsync`, `de` and `rgb` share that single pipeline stage, so they stay mutually aligned.
- `frame_tick` is high for exactly 1 cycle per 420 000 clocks (800×525).
- The first tick arrives 1 cycle after counters reach (0,480) following reset, which is 384 001 cycles after `rst` deasserts.
- Changes on the position inputs at any time other than the latch cycle have no visible effect until the next frame.
- Inputs sampled in the latch cycle are displayed starting at `vcnt`=0 of the next frame.

## Configuration
- Macro: `PONG_RENDER_NET_EN`.
- Defined: draw a dashed centre net in colour 6'b010101.
  - Net occupies `hcnt` 318..321, on lines where `vcnt`[4]=0.
  - Priority is below the ball and paddle.
- Undefined: no net logic is compiled, and those pixels are `BG_COLOR`.

## Structure
- Shared package `pong_pkg`:
  - screen size constants: 640, 480;
  - H/V timing constants: visible, front porch, sync, back porch, total;
  - reset/centre defaults;
  - colour constants.
- Sub-module `vga_timing`: owns `hcnt`/`vcnt`, produces raw sync, visible-region and `frame_start` strobes.
- `pong_vga_renderer` contains the shadow registers, hit tests, colour mux and output register.

## Test plan
- Reset, then run 2 frames → `hsync` period 800 clocks with a low width of 96. `vsync` period 420 000 clocks with a low width of 1600. Exactly 2 `frame_tick` pulses.
- `ball_x`=100, `ball_y`=50, held across a frame boundary → `rgb`=FG exactly for x 100..109, y 50..59 in the next frame; `de`=1 and `rgb`=0 elsewhere in the visible region (net disabled).
- `paddle_y`=470 → paddle drawn for y 470..479 only: clipped, no wrap to the top of the screen.
- Change `ball_x` from 100 to 300 mid-frame at `vcnt`=200 → the current frame still draws the ball at x=100; the next frame draws it at x=300.
- Assert `rst` for 1 cycle at `hcnt`=700, `vcnt`=300 → outputs take reset values; the next `frame_tick` arrives 384 001 cycles after deassertion. The ball is at (320,240) until the first latch.
- With `PONG_RENDER_NET_EN` defined → at `vcnt`=5, x 318..321 show 6'b010101; at `vcnt`=20 they show `BG_COLOR`. With the ball at (316,0), x 316..325 at y 0..9 show FG.
